// File: rtl/arbiter_bus_stream_n_in_1_out_pkg.sv
// Shared definitions for the N-to-1 stream arbiter.
//   arbiter_lock_state_t : packet-lock FSM states
//   STAT_WIDTH           : width of each per-channel grant statistics counter
//   rr_wrap_inc          : round-robin pointer advance modulo the active channel count
package arbiter_bus_stream_n_in_1_out_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arbiter_lock_state_t;

  localparam int unsigned STAT_WIDTH = 32;

  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned width);
    return (idx + 1 >= width) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arbiter_bus_stream_n_in_1_out_rr_select.sv
// Combinational rotate-priority search.
//   req_i  : per-channel requests
//   ptr_i  : highest-priority channel this cycle
//   mask_i : channels allowed to win (others ignored)
//   gnt_o  : one-hot grant (zero when nothing requests)
//   id_o   : encoded index of the granted channel
//   any_o  : a grant was made
module arbiter_bus_stream_n_in_1_out_rr_select #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  input  logic [N-1:0]   mask_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] id_o,
  output logic           any_o
);

  logic [N-1:0]   req_m;
  logic [IDW-1:0] idx;

  assign req_m = req_i & mask_i;

  // N is a power of two, so IDW-bit overflow of ptr+k is exactly the wrap modulo N.
  // Masked channels never win, which makes this equivalent to wrapping modulo the
  // active channel count.
  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_i + IDW'(k);
      if (!any_o && req_m[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = idx;
      end
    end
  end

endmodule

// File: rtl/arbiter_bus_stream_n_in_1_out.sv
// N-to-1 valid/ready stream arbiter with round-robin grant, optional packet lock
// and one registered output stage.
//   ap_clk, areset      : clock, synchronous active-high reset
//   in_valid/in_last    : per-channel beat valid / end-of-packet
//   in_bus              : per-channel payload
//   in_ready            : per-channel accept (one-hot or zero)
//   out_valid/out_last  : registered output beat valid / end-of-packet
//   out_id, out_bus     : source channel and payload of the output beat
//   out_ready           : downstream accept
//   stat_grant_count    : per-channel saturating transfer counts, present only when
//                         ARBITER_BUS_STREAM_STATS_EN is defined
module arbiter_bus_stream_n_in_1_out
  import arbiter_bus_stream_n_in_1_out_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned ARBITER_WIDTH = 2 ** $clog2(WIDTH),
  parameter int unsigned SELECT_WIDTH  = (ARBITER_WIDTH > 1) ? $clog2(ARBITER_WIDTH) : 1,
  parameter int unsigned BUS_WIDTH     = 64,
  parameter int unsigned LOCK_MODE     = 0,
  parameter int unsigned MAX_BURST     = 16
) (
  input  logic                     ap_clk,
  input  logic                     areset,
  input  logic [ARBITER_WIDTH-1:0] in_valid,
  input  logic [ARBITER_WIDTH-1:0] in_last,
  input  logic [BUS_WIDTH-1:0]     in_bus [ARBITER_WIDTH],
  output logic [ARBITER_WIDTH-1:0] in_ready,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [SELECT_WIDTH-1:0]  out_id,
  output logic [BUS_WIDTH-1:0]     out_bus,
  input  logic                     out_ready
`ifdef ARBITER_BUS_STREAM_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]    stat_grant_count [ARBITER_WIDTH]
`endif
);

  localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);
  // A one-beat burst limit releases on every transfer, so locking is pointless.
  localparam bit LockEn = (LOCK_MODE != 0) && (MAX_BURST > 1);
  localparam logic [ARBITER_WIDTH-1:0] ChanMask =
      {ARBITER_WIDTH{1'b1}} >> (ARBITER_WIDTH - WIDTH);

  typedef struct packed {
    logic                    valid;
    logic                    last;
    logic [SELECT_WIDTH-1:0] id;
    logic [BUS_WIDTH-1:0]    bus;
  } beat_t;

  beat_t                    beat_q, beat_d;
  arbiter_lock_state_t      state_q, state_d;
  logic [SELECT_WIDTH-1:0]  ptr_q, ptr_d;
  logic [SELECT_WIDTH-1:0]  lock_id_q, lock_id_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

  logic [ARBITER_WIDTH-1:0] sel_gnt;
  logic [SELECT_WIDTH-1:0]  sel_id;
  logic                     sel_any;

  logic [ARBITER_WIDTH-1:0] grant;
  logic [SELECT_WIDTH-1:0]  gnt_id;
  logic                     en;
  logic                     xfer;
  logic                     rel;

  arbiter_bus_stream_n_in_1_out_rr_select #(
    .N   (ARBITER_WIDTH),
    .IDW (SELECT_WIDTH)
  ) u_rr_select (
    .req_i  (in_valid),
    .ptr_i  (ptr_q),
    .mask_i (ChanMask),
    .gnt_o  (sel_gnt),
    .id_o   (sel_id),
    .any_o  (sel_any)
  );

  always_comb begin
    en     = ~beat_q.valid | out_ready;
    grant  = '0;
    gnt_id = sel_id;
    // While locked the grant is pinned to the owner; a gap in its valid stalls the bus
    // rather than letting another channel slip in mid-packet.
    if (state_q == ARB_LOCKED) begin
      gnt_id = lock_id_q;
      grant[lock_id_q] = in_valid[lock_id_q];
    end else if (sel_any) begin
      grant = sel_gnt;
    end
    in_ready = (areset || !en) ? '0 : grant;
    xfer     = |in_ready;
  end

  always_comb begin
    beat_d = beat_q;
    if (xfer) begin
      beat_d.valid = 1'b1;
      beat_d.last  = in_last[gnt_id];
      beat_d.id    = gnt_id;
      beat_d.bus   = in_bus[gnt_id];
    end else if (en) begin
      beat_d.valid = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    rel       = 1'b0;
    if (xfer) begin
      if (!LockEn) begin
        rel = 1'b1;
      end else if (state_q == ARB_IDLE) begin
        if (in_last[gnt_id]) begin
          rel = 1'b1;
        end else begin
          state_d   = ARB_LOCKED;
          lock_id_d = gnt_id;
          cnt_d     = CNT_WIDTH'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (in_last[gnt_id] || cnt_d == CNT_WIDTH'(MAX_BURST)) begin
          rel     = 1'b1;
          state_d = ARB_IDLE;
          cnt_d   = '0;
        end
      end
    end
    if (rel) begin
      ptr_d = SELECT_WIDTH'(rr_wrap_inc(32'(gnt_id), WIDTH));
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      beat_q    <= '0;
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      lock_id_q <= '0;
      cnt_q     <= '0;
    end else begin
      beat_q    <= beat_d;
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_id_q <= lock_id_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid = beat_q.valid;
  assign out_last  = beat_q.last;
  assign out_id    = beat_q.id;
  assign out_bus   = beat_q.bus;

`ifdef ARBITER_BUS_STREAM_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q [ARBITER_WIDTH];
  logic [STAT_WIDTH-1:0] stat_d [ARBITER_WIDTH];

  always_comb begin
    for (int i = 0; i < ARBITER_WIDTH; i++) begin
      stat_d[i] = stat_q[i];
      if (in_ready[i] && ChanMask[i] && (stat_q[i] != '1)) begin
        stat_d[i] = stat_q[i] + STAT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < ARBITER_WIDTH; i++) begin
      if (areset) begin
        stat_q[i] <= '0;
      end else begin
        stat_q[i] <= stat_d[i];
      end
    end
  end

  assign stat_grant_count = stat_q;
`endif

endmodule
